window_addr_gen: RTL
====================

// Module: window_addr_gen
// PURPOSE
//  Parametrised sliding-window address generator for the edge-detection pipeline.
//  Walks a WIN x WIN window across a runtime-sized image at stride STRIDE.
//  Issues WIN*WIN pixel read addresses per window on a valid/ready read channel.
//  Issues one sequential result write address per window on an independent write channel.
// PARAMETERS
//  ADDR_W  32  address width; all address arithmetic is modulo 2^ADDR_W
//  DIM_W   9   image width/height field width
//  WIN     3   window edge in pixels (2..7)
//  STRIDE  1   window step in pixels, both axes (1..WIN)
// PORTS
//  clk           in   1       clock
//  n_rst         in   1       async active-low reset
//  i_start       in   1       start frame; sampled only in IDLE
//  i_init_raddr  in   ADDR_W  source image base (top-left pixel); captured at start
//  i_init_waddr  in   ADDR_W  result base address; captured at start
//  i_img_width   in   DIM_W   image width W in pixels; captured at start
//  i_img_height  in   DIM_W   image height H in pixels; captured at start
//  o_raddr       out  ADDR_W  read address
//  o_rvalid      out  1       read address valid
//  i_rready      in   1       read consumer accepts; handshake = o_rvalid & i_rready
//  o_waddr       out  ADDR_W  write address
//  o_wvalid      out  1       write address valid
//  i_wready      in   1       result ready; handshake = o_wvalid & i_wready
//  o_busy        out  1       frame in progress (SETUP, RUN, DRAIN)
//  o_done        out  1       one-cycle pulse at frame end
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; all counters and pointers 0.
//  FSM: IDLE -(i_start)-> SETUP -> RUN -(last read hs)-> DRAIN -(last write hs)-> DONE -> IDLE.
//   RUN -> DONE directly if the last read hs and last write hs are both done.
//  SETUP (1 cycle):
//   - register W, H, bases; rowstep = STRIDE*W.
//   - If W<WIN or H<WIN: go to DONE with no valids. o_done is high 2 cycles after i_start.
//  Latency: o_rvalid and o_wvalid rise 2 cycles after i_start.
//   - First o_raddr = init_raddr; first o_waddr = init_waddr.
//  Read order, window at column c, row r:
//   - for wy 0..WIN-1, wx 0..WIN-1: addr = base + (r+wy)*W + (c+wx).
//   - Generated incrementally, no runtime multiply:
//     - next pixel: +1
//     - end of window row: +(W-WIN+1)
//     - end of window: winpt += STRIDE while c+STRIDE+WIN <= W
//     - otherwise rowpt += rowstep, winpt = rowpt, c = 0
//  Last window: last c with c+WIN<=W, last r with r+WIN<=H.
//   - Reads total = nwin*WIN*WIN, with nwin = ((W-WIN)/STRIDE+1)*((H-WIN)/STRIDE+1).
//  Write channel:
//   - o_waddr starts at init_waddr, +1 per write hs.
//   - o_wvalid deasserts after nwin handshakes, tracked by write col/row counters.
//  Handshake rules:
//   - o_raddr/o_waddr are stable while valid & !ready.
//   - Address advances on the cycle after a hs.
//   - Back-to-back hs sustains 1 addr/cycle per channel.
//  Read and write channels are independent; either may complete first. No credit coupling.
//  i_start while o_busy is ignored. Input changes after start have no effect.
//  Reset mid-frame: immediate return to IDLE; valids drop asynchronously; no o_done.
//  o_done is high for exactly 1 cycle in DONE. o_busy is 0 in DONE.
// TESTING
//  Case 1:
//   - Stim: WIN=3, S=1, W=H=5, raddr base 0x100, i_rready=1.
//   - Expect reads 0x100,101,102,105,106,107,10A,10B,10C; window 2 starts 0x101; window 4 starts 0x105.
//   - Expect 81 reads total.
//  Case 2:
//   - Stim: same frame, waddr 0x800, i_wready=1.
//   - Expect 9 writes 0x800..0x808 and one o_done pulse.
//   - Expect o_busy low thereafter.
//  Case 3:
//   - Stim: WIN=3, S=2, W=H=7.
//   - Expect window origins at offsets 0,2,4,14,16,18,28,30,32.
//   - Expect 81 reads and 9 writes.
//  Case 4:
//   - Stim: i_rready low 3 cycles mid-window.
//   - Expect o_raddr and o_rvalid held constant; sequence resumes unchanged.
//   - Stim: i_wready=0 until all reads finish.
//   - Expect DRAIN, then 9 writes, then done.
//  Case 5:
//   - Stim: W=2, H=5, i_start.
//   - Expect no o_rvalid/o_wvalid and o_done 2 cycles later.
//   - Stim: second i_start while busy.
//   - Expect it ignored.
//  Case 6:
//   - Stim: n_rst low after 20 reads.
//   - Expect all outputs 0 and IDLE.
//   - Stim: new i_start.
//   - Expect restart from the new base with a correct full sequence.

Source files
------------

// File: rtl/window_addr_gen.sv
// ---------------------------------------------------------------------------
// window_addr_gen
//   Sliding-window address generator for the edge-detection pipeline.
//   Walks a WIN x WIN window across a runtime-sized image at step STRIDE on
//   both axes. For each window it issues WIN*WIN pixel read addresses on a
//   valid/ready read channel. It issues one sequential result write address
//   per window on an independent valid/ready write channel.
//
// Ports
//   clk, n_rst     clock, asynchronous active-low reset
//   i_start        start a frame (sampled in IDLE only)
//   i_init_raddr   source image base (top-left pixel), captured at start
//   i_init_waddr   result base address, captured at start
//   i_img_width    image width in pixels, captured at start
//   i_img_height   image height in pixels, captured at start
//   o_raddr/o_rvalid/i_rready   pixel read address channel
//   o_waddr/o_wvalid/i_wready   result write address channel
//   o_busy         frame in progress (SETUP, RUN, DRAIN)
//   o_done         single-cycle pulse at frame end
// ---------------------------------------------------------------------------
module window_addr_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 9,
  parameter int unsigned WIN    = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_init_raddr,
  input  logic [ADDR_W-1:0] i_init_waddr,
  input  logic [DIM_W-1:0]  i_img_width,
  input  logic [DIM_W-1:0]  i_img_height,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_wvalid,
  input  logic              i_wready,
  output logic              o_busy,
  output logic              o_done
);

  // Width of the in-window pixel counters.
  localparam int unsigned WC_W  = $clog2(WIN);
  // Headroom for position + STRIDE + WIN comparisons without wrap.
  localparam int unsigned CMP_W = DIM_W + 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // State and frame configuration
  logic [2:0]        state_q,   state_d;
  logic [DIM_W-1:0]  img_w_q,   img_w_d;
  logic [DIM_W-1:0]  img_h_q,   img_h_d;
  logic [ADDR_W-1:0] rowstep_q, rowstep_d;
  logic [ADDR_W-1:0] rowinc_q,  rowinc_d;

  // Read channel: current address, window/row origin pointers, positions
  logic [ADDR_W-1:0] raddr_q,   raddr_d;
  logic [ADDR_W-1:0] winpt_q,   winpt_d;
  logic [ADDR_W-1:0] rowpt_q,   rowpt_d;
  logic [WC_W-1:0]   wx_q,      wx_d;
  logic [WC_W-1:0]   wy_q,      wy_d;
  logic [DIM_W-1:0]  rc_q,      rc_d;
  logic [DIM_W-1:0]  rr_q,      rr_d;
  logic              rvalid_q,  rvalid_d;

  // Write channel: current address and window position counters
  logic [ADDR_W-1:0] waddr_q,   waddr_d;
  logic [DIM_W-1:0]  wc_q,      wc_d;
  logic [DIM_W-1:0]  wr_q,      wr_d;
  logic              wvalid_q,  wvalid_d;

  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  // Handshakes and window-walk boundary tests
  logic rd_hs;
  logic wr_hs;
  logic col_more_r;
  logic row_more_r;
  logic col_more_w;
  logic row_more_w;
  logic px_row_end;
  logic px_win_end;

  assign rd_hs = rvalid_q & i_rready;
  assign wr_hs = wvalid_q & i_wready;

  // Another window fits to the right / below the current one.
  assign col_more_r = (CMP_W'(rc_q) + CMP_W'(STRIDE + WIN)) <= CMP_W'(img_w_q);
  assign row_more_r = (CMP_W'(rr_q) + CMP_W'(STRIDE + WIN)) <= CMP_W'(img_h_q);
  assign col_more_w = (CMP_W'(wc_q) + CMP_W'(STRIDE + WIN)) <= CMP_W'(img_w_q);
  assign row_more_w = (CMP_W'(wr_q) + CMP_W'(STRIDE + WIN)) <= CMP_W'(img_h_q);

  assign px_row_end = (wx_q == WC_W'(WIN - 1));
  assign px_win_end = px_row_end && (wy_q == WC_W'(WIN - 1));

  // Next-state, datapath and output logic
  always_comb begin
    state_d   = state_q;
    img_w_d   = img_w_q;
    img_h_d   = img_h_q;
    rowstep_d = rowstep_q;
    rowinc_d  = rowinc_q;
    raddr_d   = raddr_q;
    winpt_d   = winpt_q;
    rowpt_d   = rowpt_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    rc_d      = rc_q;
    rr_d      = rr_q;
    rvalid_d  = rvalid_q;
    waddr_d   = waddr_q;
    wc_d      = wc_q;
    wr_d      = wr_q;
    wvalid_d  = wvalid_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    // Read walk: pixel, window row, next window, next window row.
    if (rd_hs) begin
      if (!px_row_end) begin
        wx_d    = wx_q + WC_W'(1);
        raddr_d = raddr_q + ADDR_W'(1);
      end else if (!px_win_end) begin
        wx_d    = '0;
        wy_d    = wy_q + WC_W'(1);
        raddr_d = raddr_q + rowinc_q;
      end else begin
        wx_d = '0;
        wy_d = '0;
        if (col_more_r) begin
          winpt_d = winpt_q + ADDR_W'(STRIDE);
          raddr_d = winpt_q + ADDR_W'(STRIDE);
          rc_d    = rc_q + DIM_W'(STRIDE);
        end else if (row_more_r) begin
          rowpt_d = rowpt_q + rowstep_q;
          winpt_d = rowpt_q + rowstep_q;
          raddr_d = rowpt_q + rowstep_q;
          rc_d    = '0;
          rr_d    = rr_q + DIM_W'(STRIDE);
        end else begin
          rvalid_d = 1'b0;
        end
      end
    end

    // Write walk: one address per window, same window order as reads.
    if (wr_hs) begin
      waddr_d = waddr_q + ADDR_W'(1);
      if (col_more_w) begin
        wc_d = wc_q + DIM_W'(STRIDE);
      end else if (row_more_w) begin
        wc_d = '0;
        wr_d = wr_q + DIM_W'(STRIDE);
      end else begin
        wvalid_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SETUP;
          img_w_d = i_img_width;
          img_h_d = i_img_height;
          raddr_d = i_init_raddr;
          winpt_d = i_init_raddr;
          rowpt_d = i_init_raddr;
          waddr_d = i_init_waddr;
          wx_d    = '0;
          wy_d    = '0;
          rc_d    = '0;
          rr_d    = '0;
          wc_d    = '0;
          wr_d    = '0;
        end
      end
      ST_SETUP: begin
        // Constant-by-variable products only; the walk itself is add-only.
        rowstep_d = ADDR_W'(STRIDE) * ADDR_W'(img_w_q);
        rowinc_d  = ADDR_W'(img_w_q) - ADDR_W'(WIN - 1);
        if ((img_w_q < DIM_W'(WIN)) || (img_h_q < DIM_W'(WIN))) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_RUN;
          rvalid_d = 1'b1;
          wvalid_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!rvalid_d) begin
          state_d = wvalid_d ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (!wvalid_d) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SETUP) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      img_w_q   <= '0;
      img_h_q   <= '0;
      rowstep_q <= '0;
      rowinc_q  <= '0;
      raddr_q   <= '0;
      winpt_q   <= '0;
      rowpt_q   <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      rc_q      <= '0;
      rr_q      <= '0;
      rvalid_q  <= 1'b0;
      waddr_q   <= '0;
      wc_q      <= '0;
      wr_q      <= '0;
      wvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      img_w_q   <= img_w_d;
      img_h_q   <= img_h_d;
      rowstep_q <= rowstep_d;
      rowinc_q  <= rowinc_d;
      raddr_q   <= raddr_d;
      winpt_q   <= winpt_d;
      rowpt_q   <= rowpt_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      rc_q      <= rc_d;
      rr_q      <= rr_d;
      rvalid_q  <= rvalid_d;
      waddr_q   <= waddr_d;
      wc_q      <= wc_d;
      wr_q      <= wr_d;
      wvalid_q  <= wvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_raddr  = raddr_q;
  assign o_rvalid = rvalid_q;
  assign o_waddr  = waddr_q;
  assign o_wvalid = wvalid_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule
